// File: rtl/kmap_pkg.sv
// kmap_pkg: shared widths and state encoding for the Karnaugh-map sweep engine
package kmap_pkg;
    localparam int N_IN    = 4;
    localparam int VEC_CNT = 2 ** N_IN;
    localparam int CNT_W   = 4;
    localparam int MC_W    = N_IN + 1;
    typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;
endpackage

// File: rtl/kmap_result_acc.sv
// kmap_result_acc: captures sampled outputs, counts mismatches, tracks the lowest failing vector
module kmap_result_acc
    import kmap_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               clear,
    input  logic               sample_en,
    input  logic [N_IN-1:0]    idx,
    input  logic               f_in,
    input  logic               exp_bit,
    output logic [VEC_CNT-1:0] truth_table,
    output logic [MC_W-1:0]    mismatch_cnt,
    output logic [N_IN-1:0]    first_fail,
    output logic               first_fail_vld
);

    // Clear on a new sweep; otherwise fold one sample per enabled cycle into the results
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            truth_table    <= '0;
            mismatch_cnt   <= '0;
            first_fail     <= '0;
            first_fail_vld <= 1'b0;
        end else if (clear) begin
            truth_table    <= '0;
            mismatch_cnt   <= '0;
            first_fail     <= '0;
            first_fail_vld <= 1'b0;
        end else if (sample_en) begin
            truth_table[idx] <= f_in;
            if (f_in != exp_bit) begin
                mismatch_cnt <= mismatch_cnt + MC_W'(1);
                if (!first_fail_vld) begin
                    first_fail     <= idx;
                    first_fail_vld <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/kmap_sweep_ctrl.sv
// kmap_sweep_ctrl: steps a 4-input function block through all vectors and checks it against a golden table
module kmap_sweep_ctrl
    import kmap_pkg::*;
#(
    parameter int SETTLE_CYC = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               abort,
    input  logic [VEC_CNT-1:0] expected,
    input  logic               f_in,
    output logic [N_IN-1:0]    vec_out,
    output logic               busy,
    output logic               done,
    output logic [VEC_CNT-1:0] truth_table,
    output logic [MC_W-1:0]    mismatch_cnt,
    output logic [N_IN-1:0]    first_fail,
    output logic               first_fail_vld,
    output logic               pass
);

    state_t             state;
    logic [N_IN-1:0]    idx;
    logic [CNT_W-1:0]   cnt;
    logic [VEC_CNT-1:0] exp_latch;
    logic               clear;
    logic               sample_en;

    // A same-cycle abort suppresses the sample write and wins over start
    always_comb begin
        clear     = (state == IDLE) && start && !abort;
        sample_en = (state == SAMPLE) && !abort;
    end

    // Sweep sequencer: settle each vector, sample it, advance, then pulse done
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            vec_out   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            idx       <= '0;
            cnt       <= '0;
            exp_latch <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (clear) begin
                    exp_latch <= expected;
                    pass      <= 1'b0;
                    idx       <= '0;
                    cnt       <= '0;
                    vec_out   <= '0;
                    busy      <= 1'b1;
                    state     <= SETTLE;
                end
                SETTLE: if (abort) begin
                    state   <= IDLE;
                    busy    <= 1'b0;
                    vec_out <= '0;
                end else begin
                    cnt <= cnt + CNT_W'(1);
                    if (cnt == CNT_W'(SETTLE_CYC - 1))
                        state <= SAMPLE;
                end
                SAMPLE: if (abort) begin
                    state   <= IDLE;
                    busy    <= 1'b0;
                    vec_out <= '0;
                end else if (idx == N_IN'(VEC_CNT - 1)) begin
                    // Fold in the last sample so pass is valid alongside done
                    pass  <= (mismatch_cnt == '0) && (f_in == exp_latch[idx]);
                    done  <= 1'b1;
                    state <= DONE;
                end else begin
                    idx     <= idx + N_IN'(1);
                    vec_out <= idx + N_IN'(1);
                    cnt     <= '0;
                    state   <= SETTLE;
                end
                DONE: begin
                    busy    <= 1'b0;
                    vec_out <= '0;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    kmap_result_acc u_acc (
        .clk            (clk),
        .rst            (rst),
        .clear          (clear),
        .sample_en      (sample_en),
        .idx            (idx),
        .f_in           (f_in),
        .exp_bit        (exp_latch[idx]),
        .truth_table    (truth_table),
        .mismatch_cnt   (mismatch_cnt),
        .first_fail     (first_fail),
        .first_fail_vld (first_fail_vld)
    );

endmodule

// File: doc/kmap_sweep_ctrl.md
Name: kmap_sweep_ctrl

Overview:
Sequencer that exhaustively drives a 4-input combinational Karnaugh-map function block (a,b,c,d -> o) through all 16 input vectors. It captures the block's output into a truth-table register and checks it against an expected table. It sits beside the function block in self-checking hardware, replacing the hand-written vector sweep with a start/done controlled engine.

Parameters:
N_IN, 4, number of function inputs; VEC_CNT = 2**N_IN vectors per sweep
SETTLE_CYC, 1, cycles vec_out is held before f_in is sampled (legal range 1..15)

Ports:
clk            in   1         rising-edge clock
rst            in   1         asynchronous, active-high reset
start          in   1         request a sweep; accepted only in IDLE
abort          in   1         synchronous abort of a running sweep
expected       in   VEC_CNT   golden truth table; bit i = expected o for vector i; latched on start acceptance
f_in           in   1         output o of the function block under control
vec_out        out  N_IN      drive to function block, packed {a,b,c,d}, a = MSB
busy           out  1         high from start acceptance until the DONE cycle inclusive
done           out  1         one-cycle pulse at sweep completion
truth_table    out  VEC_CNT   captured f_in per vector
mismatch_cnt   out  N_IN+1    number of vectors where f_in != expected bit
first_fail     out  N_IN      lowest failing vector index
first_fail_vld out  1         at least one mismatch recorded
pass           out  1         mismatch_cnt == 0, updated in the DONE cycle

Behaviour:
- Reset (async, rst=1): state=IDLE; vec_out=0; busy=0; done=0; truth_table=0; mismatch_cnt=0; first_fail=0; first_fail_vld=0; pass=0; internal idx, settle counter and expected latch = 0.
- States: IDLE, SETTLE, SAMPLE, DONE.
- IDLE: vec_out=0. start=1 (and abort=0) -> latch expected; clear truth_table, mismatch_cnt, first_fail, first_fail_vld, pass; idx=0; cnt=0; go to SETTLE.
- SETTLE: vec_out=idx. cnt increments each cycle. When cnt==SETTLE_CYC-1, go to SAMPLE.
- SAMPLE: vec_out=idx. truth_table[idx] <= f_in.
  - If f_in != exp_latch[idx]: mismatch_cnt++.
  - If that mismatch occurs with first_fail_vld=0: first_fail<=idx and first_fail_vld<=1.
  - If idx==VEC_CNT-1, go to DONE. Otherwise idx++, cnt=0, go to SETTLE.
- DONE: done=1 and busy=1 for exactly one cycle; pass <= (mismatch_cnt==0), using the final updated count; next state IDLE.
- Latency: with start accepted at edge 0, done is high in the cycle after edge VEC_CNT*(SETTLE_CYC+1). Default settings give 32 cycles of sweep followed by 1 DONE cycle.
- start outside IDLE is ignored; requests are not queued.
- abort=1 in SETTLE or SAMPLE -> IDLE next cycle. No done pulse is produced, and pass stays 0. Partial truth_table and mismatch results are held. An abort in the same cycle as a SAMPLE write suppresses that write. abort has priority over start.
- Results stay stable in IDLE until the next accepted start.
- Width: mismatch_cnt is N_IN+1 bits, so it counts VEC_CNT without wrap (16 = 5'b10000). idx is N_IN bits and never wraps inside a sweep.
- The expected input may change during a sweep without effect; only the latched copy is used.
- rst mid-sweep: immediate return to the reset values above.

Decomposition:
- Package kmap_pkg holds N_IN, VEC_CNT, the state enum (IDLE/SETTLE/SAMPLE/DONE) and the counter width constants.
- One natural sub-module, kmap_result_acc, holds truth_table capture, the mismatch counter and first-fail tracking. It is driven by sample_en, idx, f_in and exp_bit, plus clear and rst.
- The FSM and the settle counter stay in kmap_sweep_ctrl.

Test Plan:
1. Behavioural model of the function (table 16'hA5C3) drives f_in from vec_out; expected=16'hA5C3; start pulse -> vec_out steps 0..15; done at cycle 33; truth_table=16'hA5C3, mismatch_cnt=0, first_fail_vld=0, pass=1.
2. Same model with bit 6 inverted -> truth_table=16'hA583, mismatch_cnt=1, first_fail=6, first_fail_vld=1, pass=0.
3. f_in tied 0, expected=16'hFFFF -> mismatch_cnt=5'b10000, first_fail=0, pass=0, truth_table=0.
4. start re-pulsed at cycle 10 and expected changed mid-sweep -> no restart; results match the table latched at first start; exactly one done pulse.
5. abort while idx=5 -> IDLE next cycle; no done; truth_table bits 0..4 hold captured values and bits 5..15 are 0. Then rst asserted mid-sweep -> all outputs reset asynchronously, before the next clock edge.
6. SETTLE_CYC=3 -> each vec_out value held 4 cycles; f_in sampled only on the last cycle of each; done at cycle 65. A glitch on f_in during settle cycles does not affect results.
